// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU request front-end: opcodes, flag
// bit positions, canonical quiet NaN and the result FIFO entry layout.
package fpu_issue_pkg;

  localparam int FLAG_W    = 8;
  localparam int RSP_TAG_W = 4;

  localparam int FLG_INF  = 0;
  localparam int FLG_SNAN = 1;
  localparam int FLG_QNAN = 2;
  localparam int FLG_INE  = 3;
  localparam int FLG_OVF  = 4;
  localparam int FLG_UNF  = 5;
  localparam int FLG_ZERO = 6;
  localparam int FLG_DBZ  = 7;

  localparam logic [31:0]       QNAN_CANON = 32'h7FC0_0000;
  localparam logic [FLAG_W-1:0] QNAN_FLAGS = FLAG_W'(1) << FLG_QNAN;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    I2F = 3'd4,
    F2I = 3'd5
  } fpu_op_e;

  typedef struct packed {
    logic [31:0]          data;
    logic [FLAG_W-1:0]    flags;
    logic [RSP_TAG_W-1:0] tag;
  } rsp_entry_t;

  // Opcodes 6 and 7 have no FPU meaning; they still flow through in order.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return op > 3'(F2I);
  endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous circular-buffer FIFO holding FPU results until the consumer
// pops them; the head is presented from storage with no push fall-through.
module fpu_rsp_fifo
  import fpu_issue_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = rsp_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? entry_t'('0) : mem_q[rd_ptr_q];

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // so the order of statements and blocks cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates what is visible,
  // and leaving the array off the reset net keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Front-end for a fixed-latency FPU: registers accepted requests onto the FPU
// inputs, tracks them in a tagged valid pipeline and queues the results.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = RSP_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [1:0]        req_rmode,
  input  logic [31:0]       req_opa,
  input  logic [31:0]       req_opb,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [2:0]        fpu_op,
  output logic [1:0]        fpu_rmode,
  output logic [31:0]       fpu_opa,
  output logic [31:0]       fpu_opb,
  input  logic [31:0]       fpu_out,
  input  logic [FLAG_W-1:0] fpu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              sticky_clr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef struct packed {
    logic             vld;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [CW-1:0]     used_q, used_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        rmode_q, rmode_d;
  logic [31:0]       opa_q, opa_d;
  logic [31:0]       opb_q, opb_d;
  logic [FLAG_W-1:0] sticky_q, sticky_d;
  stage_t            pipe_q [LATENCY];
  stage_t            pipe_d [LATENCY];

  logic       accept, pop, push;
  logic       fifo_full, fifo_empty;
  stage_t     last_stage;
  rsp_entry_t push_entry, head_entry;

  // Ready comes from the credit register alone, never from req_valid.
  assign req_ready  = (used_q < DEPTH_CNT);
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = !fifo_empty;
  assign pop        = rsp_valid && rsp_ready;
  assign last_stage = pipe_q[LATENCY-1];
  assign push       = last_stage.vld;

  always_comb begin
    used_d  = used_q;
    op_d    = op_q;
    rmode_d = rmode_q;
    opa_d   = opa_q;
    opb_d   = opb_q;

    unique case ({accept, pop})
      2'b10:   used_d = used_q + CW'(1);
      2'b01:   used_d = used_q - CW'(1);
      default: used_d = used_q;
    endcase

    // The FPU inputs only move on an accept, so it never sees an unowned value.
    if (accept) begin
      op_d    = req_op;
      rmode_d = req_rmode;
      opa_d   = req_opa;
      opb_d   = req_opb;
    end

    pipe_d[0].vld = accept;
    pipe_d[0].ill = op_is_illegal(req_op);
    pipe_d[0].tag = req_tag;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    push_entry.data  = last_stage.ill ? QNAN_CANON : fpu_out;
    push_entry.flags = last_stage.ill ? QNAN_FLAGS : fpu_flags;
    push_entry.tag   = RSP_TAG_W'(last_stage.tag);

    // A clear coinciding with a push leaves exactly the pushed flags.
    sticky_d = (sticky_clr ? '0 : sticky_q) | (push ? push_entry.flags : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q   <= '0;
      op_q     <= '0;
      rmode_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sticky_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      used_q   <= used_d;
      op_q     <= op_d;
      rmode_q  <= rmode_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sticky_q <= sticky_d;
      pipe_q   <= pipe_d;
    end
  end

  fpu_rsp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (rsp_entry_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fpu_op       = op_q;
  assign fpu_rmode    = rmode_q;
  assign fpu_opa      = opa_q;
  assign fpu_opb      = opb_q;
  assign rsp_data     = head_entry.data;
  assign rsp_flags    = head_entry.flags;
  assign rsp_tag      = TAG_W'(head_entry.tag);
  assign sticky_flags = sticky_q;

  // Credits cap outstanding work at DEPTH, so a capture can never meet a full FIFO.
  assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full)
    else $error("result captured while the response FIFO is full");

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a stand-in fixed-latency FPU plus a queue-based
// model of accepted requests, checked every cycle, with directed scenarios.
module tb_fpu_issue_ctrl;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = '0;
  logic [1:0]        req_rmode = '0;
  logic [31:0]       req_opa = '0;
  logic [31:0]       req_opb = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [2:0]        fpu_op;
  logic [1:0]        fpu_rmode;
  logic [31:0]       fpu_opa;
  logic [31:0]       fpu_opb;
  logic [31:0]       fpu_out;
  logic [7:0]        fpu_flags;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [7:0]        rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;
  logic [7:0]        sticky_flags;
  logic              sticky_clr = 1'b0;

  fpu_issue_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rmode(req_rmode), .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
    .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  // Stand-in FPU: a few exact IEEE cases, otherwise a fixed scramble of the operands.
  function automatic logic [39:0] fpu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd0 && a == 32'h4040_0000 && b == 32'h3FC0_0000) return {32'h4090_0000, 8'h00};
    if (op == 3'd3 && a == 32'h3F80_0000 && b == 32'h0000_0000) return {32'h7F80_0000, 8'h81};
    if (op == 3'd1 && a == 32'h3F80_0000 && b == 32'h3DCC_CCCD) return {32'h3F66_6666, 8'h08};
    return {a ^ {b[15:0], b[31:16]} ^ {29'd0, op}, a[7:0] ^ b[31:24]};
  endfunction

  // Result sampled LATENCY edges after the operands change: LATENCY-1 stages
  // here plus the edge on which the operands themselves were loaded.
  logic [39:0] fpu_pipe [LATENCY-1];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_fn(fpu_op, fpu_opa, fpu_opb);
    for (int i = 1; i < LATENCY - 1; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign {fpu_out, fpu_flags} = fpu_pipe[LATENCY-2];

  typedef struct {
    logic [31:0]      data;
    logic [7:0]       flags;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t        pend_q[$];
  exp_t        fifo_m[$];
  logic [7:0]  sticky_m;
  logic [2:0]  op_m;
  logic [1:0]  rmode_m;
  logic [31:0] opa_m, opb_m;
  int          edge_cnt = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("req_ready", req_ready, (pend_q.size() + fifo_m.size()) < DEPTH);
    check("rsp_valid", rsp_valid, fifo_m.size() > 0);
    if (fifo_m.size() > 0) begin
      check("rsp_data", rsp_data, fifo_m[0].data);
      check("rsp_flags", rsp_flags, fifo_m[0].flags);
      check("rsp_tag", rsp_tag, fifo_m[0].tag);
    end
    check("sticky", sticky_flags, sticky_m);
    check("fpu_op", fpu_op, op_m);
    check("fpu_rmode", fpu_rmode, rmode_m);
    check("fpu_opa", fpu_opa, opa_m);
    check("fpu_opb", fpu_opb, opb_m);
  endtask

  // Inputs are set at the negedge; advance the model across one posedge and compare.
  task automatic tick();
    bit          acc, pp, pushed;
    logic [7:0]  pflags;
    logic [39:0] r;
    exp_t        e;
    acc    = req_valid && ((pend_q.size() + fifo_m.size()) < DEPTH);
    pp     = rsp_ready && (fifo_m.size() > 0);
    pushed = 1'b0;
    pflags = 8'h00;
    edge_cnt++;
    if (pp) void'(fifo_m.pop_front());
    if (pend_q.size() > 0 && pend_q[0].due == edge_cnt) begin
      e = pend_q.pop_front();
      fifo_m.push_back(e);
      pushed = 1'b1;
      pflags = e.flags;
    end
    sticky_m = (sticky_clr ? 8'h00 : sticky_m) | (pushed ? pflags : 8'h00);
    if (acc) begin
      r       = fpu_fn(req_op, req_opa, req_opb);
      e.data  = (req_op >= 3'd6) ? 32'h7FC0_0000 : r[39:8];
      e.flags = (req_op >= 3'd6) ? 8'h04 : r[7:0];
      e.tag   = req_tag;
      e.due   = edge_cnt + LATENCY;
      pend_q.push_back(e);
      op_m = req_op; rmode_m = req_rmode; opa_m = req_opa; opb_m = req_opb;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    req_valid = 1'b0; rsp_ready = 1'b0; sticky_clr = 1'b0;
    rst = 1'b1;
    pend_q.delete();
    fifo_m.delete();
    sticky_m = '0; op_m = '0; rmode_m = '0; opa_m = '0; opb_m = '0;
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
    req_valid = 1'b1; req_op = op; req_rmode = 2'd0;
    req_opa = a; req_opb = b; req_tag = tag;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_fpu_opa", fpu_opa, 32'h0);

    // 1: single add, visible exactly LATENCY edges after the accept.
    set_req(3'd0, 32'h4040_0000, 32'h3FC0_0000, 4'd5);
    tick();
    req_valid = 1'b0;
    idle(LATENCY - 1);
    check("t1_not_early", rsp_valid, 1'b0);
    tick();
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_data", rsp_data, 32'h4090_0000);
    check("t1_tag", rsp_tag, 4'd5);
    check("t1_flags", rsp_flags, 8'h00);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // 2: nine back-to-back with no pops; the ninth waits for a credit.
    for (int i = 0; i < 9; i++) begin
      set_req(3'($urandom_range(0, 5)), $urandom, $urandom, 4'(i));
      tick();
      if (i == 7) check("t2_ready_low_after_8", req_ready, 1'b0);
    end
    idle(LATENCY);
    check("t2_still_held", req_ready, 1'b0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    check("t2_ready_after_pop", req_ready, 1'b1);
    check("t2_next_tag", rsp_tag, 4'd1);
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(DEPTH + LATENCY + 2);
    rsp_ready = 1'b0;

    // 3: divide by zero, then clear the sticky summary.
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    set_req(3'd3, 32'h3F80_0000, 32'h0, 4'd3);
    tick();
    req_valid = 1'b0;
    idle(LATENCY);
    check("t3_data", rsp_data, 32'h7F80_0000);
    check("t3_flags", rsp_flags, 8'h81);
    check("t3_sticky", sticky_flags, 8'h81);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("t3_sticky_clr", sticky_flags, 8'h00);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // 6: clear in the same cycle as a push of ine.
    set_req(3'd3, 32'h3F80_0000, 32'h0, 4'd6);
    tick();
    set_req(3'd1, 32'h3F80_0000, 32'h3DCC_CCCD, 4'd7);
    tick();
    req_valid = 1'b0;
    idle(LATENCY - 1);
    check("t6_prior_sticky", sticky_flags, 8'h81);
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    check("t6_sticky", sticky_flags, 8'h08);
    rsp_ready = 1'b1; idle(3); rsp_ready = 1'b0;

    // 4: an illegal opcode between two legal ones.
    set_req(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 4'd1); tick();
    set_req(3'd7, 32'h1111_1111, 32'h2222_2222, 4'd2); tick();
    check("t4_illegal_issued", fpu_op, 3'd7);
    set_req(3'd2, 32'h3333_3333, 32'h4444_4444, 4'd3); tick();
    req_valid = 1'b0;
    idle(LATENCY);
    check("t4_tag0", rsp_tag, 4'd1);
    rsp_ready = 1'b1; tick();
    check("t4_ill_data", rsp_data, 32'h7FC0_0000);
    check("t4_ill_flags", rsp_flags, 8'h04);
    check("t4_tag1", rsp_tag, 4'd2);
    tick();
    check("t4_tag2", rsp_tag, 4'd3);
    tick(); rsp_ready = 1'b0;

    // 5: reset with three operations in flight discards them all.
    set_req(3'd3, 32'h3F80_0000, 32'h0, 4'd9); tick();
    set_req(3'd0, 32'h5, 32'h6, 4'd10); tick();
    set_req(3'd2, 32'h7, 32'h8, 4'd11); tick();
    do_reset();
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_req_ready", req_ready, 1'b1);
    check("t5_sticky", sticky_flags, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_no_stale_rsp", rsp_valid, 1'b0);
    end

    // Random traffic, back-pressure, clears and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_op     = 3'($urandom_range(0, 7));
      req_rmode  = 2'($urandom);
      req_opa    = $urandom;
      req_opb    = $urandom;
      req_tag    = 4'($urandom);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
